// File: rtl/hng_serial_acc.sv
// Bit-serial accumulator built around a single HNG reversible gate used as a full adder.
// Optional saturation on overflow is enabled by defining HNG_ACC_SAT_EN.

module hng_gate (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic p,
    output logic q,
    output logic r,
    output logic s
);
    assign p = a;
    assign q = b;
    assign r = a ^ b ^ c;
    assign s = ((a ^ b) & c) ^ (a & b) ^ d;
endmodule

module hng_serial_acc #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);
    localparam int IDX_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        EMIT = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ACC_W-1:0]   acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [ACC_W-1:0]   op_ext_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic               last_r;
    logic               ovf_r;
    logic               out_valid_r;
    logic               accept_s;
    logic               last_bit_s;
    logic               gate_p_s;
    logic               gate_q_s;
    logic               gate_r_s;
    logic               gate_s_s;
    logic               unused_s;

    assign op_ext_s   = ACC_W'(opnd_r);
    assign in_ready   = (state_r == IDLE) && !out_valid_r;
    assign accept_s   = in_valid && in_ready;
    assign last_bit_s = (idx_r == LAST_IDX);
    assign out_valid  = out_valid_r;
    assign out_sum    = acc_r;
    assign out_ovf    = ovf_r;
    assign busy       = (state_r != IDLE);

    // The pass-through outputs of the gate carry no information here.
    assign unused_s   = gate_p_s ^ gate_q_s;

    hng_gate u_hng (
        .a (acc_r[idx_r]),
        .b (op_ext_s[idx_r]),
        .c (carry_r),
        .d (1'b0),
        .p (gate_p_s),
        .q (gate_q_s),
        .r (gate_r_s),
        .s (gate_s_s)
    );

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (last_bit_s) begin
                    state_nxt_s = last_r ? EMIT : IDLE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: operand capture, serial add one bit per cycle, result hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= {ACC_W{1'b0}};
            opnd_r      <= {WIDTH{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            carry_r     <= 1'b0;
            last_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opnd_r  <= in_data;
                        last_r  <= in_last;
                        carry_r <= 1'b0;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                ADD: begin
                    acc_r[idx_r] <= gate_r_s;
                    carry_r      <= gate_s_s;
                    idx_r        <= idx_r + IDX_W'(1);
                    if (last_bit_s) begin
                        ovf_r       <= ovf_r | gate_s_s;
                        out_valid_r <= last_r;
`ifdef HNG_ACC_SAT_EN
                        // Later NBA wins over the single-bit write above.
                        if (gate_s_s) begin
                            acc_r <= {ACC_W{1'b1}};
                        end
`endif
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        acc_r       <= {ACC_W{1'b0}};
                        ovf_r       <= 1'b0;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hng_serial_acc.sv
// Directed self-checking bench for hng_serial_acc (ACC_W=16 and ACC_W=8 instances) and hng_gate.
module tb_hng_serial_acc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v16 = 1'b0, l16 = 1'b0, ordy16 = 1'b0;
    logic [7:0]  d16 = 8'h00;
    logic        rdy16, ov16v, ovf16, busy16;
    logic [15:0] sum16;

    logic        v8 = 1'b0, l8 = 1'b0, ordy8 = 1'b0;
    logic [7:0]  d8 = 8'h00;
    logic        rdy8, ov8v, ovf8, busy8;
    logic [7:0]  sum8;

    logic        ga = 1'b0, gb = 1'b0, gc = 1'b0, gd = 1'b0;
    logic        gp, gq, gr, gs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hng_serial_acc #(.WIDTH(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .in_data(d16),
        .in_last(l16), .out_valid(ov16v), .out_ready(ordy16), .out_sum(sum16),
        .out_ovf(ovf16), .busy(busy16)
    );

    hng_serial_acc #(.WIDTH(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
        .in_last(l8), .out_valid(ov8v), .out_ready(ordy8), .out_sum(sum8),
        .out_ovf(ovf8), .busy(busy8)
    );

    hng_gate u_gate (.a(ga), .b(gb), .c(gc), .d(gd), .p(gp), .q(gq), .r(gr), .s(gs));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [7:0] d, input logic l);
        int k = 0;
        v16 = 1'b1; d16 = d; l16 = l;
        while (!rdy16 && k < 100) begin tick(); k++; end
        vectors++;
        if (rdy16 !== 1'b1) begin
            $display("FAIL send16_ready got=%b want=1", rdy16); miscompares++;
        end
        tick();
        v16 = 1'b0; d16 = 8'h00; l16 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d, input logic l);
        int k = 0;
        v8 = 1'b1; d8 = d; l8 = l;
        while (!rdy8 && k < 100) begin tick(); k++; end
        vectors++;
        if (rdy8 !== 1'b1) begin
            $display("FAIL send8_ready got=%b want=1", rdy8); miscompares++;
        end
        tick();
        v8 = 1'b0; d8 = 8'h00; l8 = 1'b0;
    endtask

    task automatic wait_out16(output int n);
        n = 1;
        while (ov16v !== 1'b1 && n < 100) begin tick(); n++; end
    endtask

    task automatic wait_rdy16(output int n);
        n = 1;
        while (rdy16 !== 1'b1 && n < 100) begin tick(); n++; end
    endtask

    task automatic emit16();
        ordy16 = 1'b1;
        tick();
        ordy16 = 1'b0;
        vectors++;
        if (ov16v !== 1'b0 || rdy16 !== 1'b1) begin
            $display("FAIL emit16_release out_valid=%b in_ready=%b want 0/1", ov16v, rdy16);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        vectors++;
        if (busy16 !== 1'b0 || ov16v !== 1'b0 || ovf16 !== 1'b0 || sum16 !== 16'd0) begin
            $display("FAIL reset16 busy=%b out_valid=%b ovf=%b sum=%0d want 0/0/0/0",
                     busy16, ov16v, ovf16, sum16);
            miscompares++;
        end
        vectors++;
        if (busy8 !== 1'b0 || ov8v !== 1'b0 || ovf8 !== 1'b0 || sum8 !== 8'd0) begin
            $display("FAIL reset8 busy=%b out_valid=%b ovf=%b sum=%0d want 0/0/0/0",
                     busy8, ov8v, ovf8, sum8);
            miscompares++;
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (rdy16 !== 1'b1 || rdy8 !== 1'b1) begin
            $display("FAIL reset_ready in_ready16=%b in_ready8=%b want 1/1", rdy16, rdy8);
            miscompares++;
        end
    endtask

    task automatic test_basic();
        int n;
        send16(8'd3, 1'b0);
        vectors++;
        if (busy16 !== 1'b1 || rdy16 !== 1'b0) begin
            $display("FAIL basic_busy busy=%b in_ready=%b want 1/0", busy16, rdy16); miscompares++;
        end
        wait_rdy16(n);
        vectors++;
        if (n != 17) begin
            $display("FAIL basic_ready_latency got=%0d want=17", n); miscompares++;
        end
        send16(8'd4, 1'b1);
        wait_out16(n);
        vectors++;
        if (n != 17) begin
            $display("FAIL basic_out_latency got=%0d want=17", n); miscompares++;
        end
        vectors++;
        if (sum16 !== 16'd7 || ovf16 !== 1'b0 || rdy16 !== 1'b0) begin
            $display("FAIL basic_result sum=%0d ovf=%b in_ready=%b want 7/0/0", sum16, ovf16, rdy16);
            miscompares++;
        end
        emit16();
    endtask

    task automatic test_overflow();
        int k = 0;
        logic [7:0] exp_sum;
`ifdef HNG_ACC_SAT_EN
        exp_sum = 8'd255;
`else
        exp_sum = 8'd44;
`endif
        send8(8'd200, 1'b0);
        send8(8'd100, 1'b1);
        while (ov8v !== 1'b1 && k < 100) begin tick(); k++; end
        vectors++;
        if (sum8 !== exp_sum || ovf8 !== 1'b1) begin
            $display("FAIL overflow sum=%0d ovf=%b want %0d/1", sum8, ovf8, exp_sum);
            miscompares++;
        end
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0;
        vectors++;
        if (ov8v !== 1'b0 || ovf8 !== 1'b0 || sum8 !== 8'd0) begin
            $display("FAIL overflow_clear out_valid=%b ovf=%b sum=%0d want 0/0/0", ov8v, ovf8, sum8);
            miscompares++;
        end
    endtask

    task automatic test_hold();
        int n;
        send16(8'hFF, 1'b1);
        wait_out16(n);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (ov16v !== 1'b1 || sum16 !== 16'd255 || rdy16 !== 1'b0) begin
                $display("FAIL hold_cycle%0d out_valid=%b sum=%0d in_ready=%b want 1/255/0",
                         i, ov16v, sum16, rdy16);
                miscompares++;
            end
            tick();
        end
        emit16();
        vectors++;
        if (sum16 !== 16'd0) begin
            $display("FAIL hold_acc_clear sum=%0d want=0", sum16); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [3] = '{8'd10, 8'd20, 8'd30};
        int k = 0;
        int cyc = 0;
        int last_acc = 0;
        int n;
        v16 = 1'b1;
        while (k < 3 && cyc < 200) begin
            if (rdy16 === 1'b1) begin
                d16 = ops[k];
                l16 = (k == 2);
                if (k > 0) begin
                    vectors++;
                    if (cyc - last_acc != 17) begin
                        $display("FAIL b2b_spacing%0d got=%0d want=17", k, cyc - last_acc);
                        miscompares++;
                    end
                end
                last_acc = cyc;
                k++;
            end else begin
                d16 = 8'($urandom);
                l16 = 1'($urandom);
            end
            tick();
            cyc++;
        end
        v16 = 1'b0; l16 = 1'b0;
        vectors++;
        if (k != 3) begin
            $display("FAIL b2b_accepts got=%0d want=3", k); miscompares++;
        end
        wait_out16(n);
        vectors++;
        if (sum16 !== 16'd60 || ovf16 !== 1'b0) begin
            $display("FAIL b2b_result sum=%0d ovf=%b want 60/0", sum16, ovf16); miscompares++;
        end
        emit16();
    endtask

    task automatic test_reset_mid();
        int n;
        send16(8'd50, 1'b1);
        repeat (4) tick();
        vectors++;
        if (busy16 !== 1'b1) begin
            $display("FAIL mid_busy got=%b want=1", busy16); miscompares++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy16 !== 1'b0 || ov16v !== 1'b0 || ovf16 !== 1'b0 || sum16 !== 16'd0) begin
            $display("FAIL mid_reset busy=%b out_valid=%b ovf=%b sum=%0d want 0/0/0/0",
                     busy16, ov16v, ovf16, sum16);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if (rdy16 !== 1'b1) begin
            $display("FAIL mid_ready got=%b want=1", rdy16); miscompares++;
        end
        send16(8'd9, 1'b1);
        wait_out16(n);
        vectors++;
        if (sum16 !== 16'd9 || ovf16 !== 1'b0) begin
            $display("FAIL mid_new_seq sum=%0d ovf=%b want 9/0", sum16, ovf16); miscompares++;
        end
        emit16();
    endtask

    task automatic test_gate();
        logic exp_r, exp_s;
        for (int i = 0; i < 16; i++) begin
            {ga, gb, gc, gd} = 4'(i);
            #1;
            exp_r = ga ^ gb ^ gc;
            exp_s = ((ga & gb) | (gc & (ga ^ gb))) ^ gd;
            vectors++;
            if (gr !== exp_r || gs !== exp_s || gp !== ga || gq !== gb) begin
                $display("FAIL gate_abcd=%0d r=%b s=%b p=%b q=%b want %b/%b/%b/%b",
                         i, gr, gs, gp, gq, exp_r, exp_s, ga, gb);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_gate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
